// File: rtl/regwb_pkg.sv
// Shared definitions for the dual-issue writeback arbiter.
//   REG_W / NREG  : register specifier width and register count.
//   REG_ZERO      : hard-wired zero register; writes to it are dropped.
//   ldq_tag_t     : control part of a load-queue entry (valid + destination).
//                   Entry data is kept beside the tag, sized by the DATA_W
//                   parameter of the module that owns the queue.
//   reg_live()    : true when a write is valid and does not target REG_ZERO.
package regwb_pkg;

  localparam int REG_W = 5;
  localparam int NREG  = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
  } ldq_tag_t;

  function automatic logic reg_live(input logic v, input logic [REG_W-1:0] r);
    return v && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/regwb_ldq.sv
// Load-return queue: LDQ_DEPTH-entry circular buffer with one push and up to
// two pops per cycle, an in-place kill vector, and head / head+1 peek ports.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, push_tag,     enqueue one entry at the tail (tag may arrive with
//   push_data           vld=0 when the load was overwritten in the same cycle)
//   pop_cnt             entries retired from the head this cycle (0..2)
//   kill                per-slot valid clear (younger ALU write to same reg)
//   count               occupied slots, including killed ones not yet popped
//   tags                every slot's tag; retired slots always read vld=0
//   head_*, next_*      tag/data of the head and head+1 slots
module regwb_ldq
  import regwb_pkg::*;
#(
  parameter int LDQ_DEPTH = 4,
  parameter int DATA_W    = 32,
  localparam int PTR_W    = $clog2(LDQ_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  ldq_tag_t                    push_tag,
  input  logic [DATA_W-1:0]           push_data,
  input  logic [1:0]                  pop_cnt,
  input  logic [LDQ_DEPTH-1:0]        kill,
  output logic [CNT_W-1:0]            count,
  output ldq_tag_t [LDQ_DEPTH-1:0]    tags,
  output ldq_tag_t                    head_tag,
  output ldq_tag_t                    next_tag,
  output logic [DATA_W-1:0]           head_data,
  output logic [DATA_W-1:0]           next_data
);

  logic [PTR_W-1:0]         head_q;
  logic [PTR_W-1:0]         tail_q;
  logic [PTR_W-1:0]         next_ptr;
  logic [CNT_W-1:0]         count_q;
  ldq_tag_t [LDQ_DEPTH-1:0] tag_q;
  logic [DATA_W-1:0]        data_q [LDQ_DEPTH];

  assign next_ptr  = head_q + PTR_W'(1);
  assign count     = count_q;
  assign tags      = tag_q;
  assign head_tag  = tag_q[head_q];
  assign next_tag  = tag_q[next_ptr];
  assign head_data = data_q[head_q];
  assign next_data = data_q[next_ptr];

  // Queue state update. Retired slots get vld cleared so that the tag array
  // alone tells which registers still have a pending load. A push never
  // lands on a slot being popped: push needs count < LDQ_DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      tag_q   <= '0;
    end else begin
      for (int i = 0; i < LDQ_DEPTH; i++) begin
        if (kill[i]) tag_q[i].vld <= 1'b0;
      end
      if (pop_cnt != 2'd0) tag_q[head_q].vld   <= 1'b0;
      if (pop_cnt == 2'd2) tag_q[next_ptr].vld <= 1'b0;
      if (push)            tag_q[tail_q]       <= push_tag;
      head_q  <= head_q + PTR_W'(pop_cnt);
      tail_q  <= tail_q + PTR_W'(push);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push) data_q[tail_q] <= push_data;
  end

endmodule

// File: rtl/regwb_arb.sv
// Dual-issue writeback arbiter: merges two ALU lanes and late load returns
// onto the two register-file write ports, buffering loads that find no free
// port and resolving same-cycle write-after-write so only the youngest write
// to a register is driven.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   alu0_valid/alu0_reg/alu0_data   lane 0 result (owns write port 0)
//   alu1_valid/alu1_reg/alu1_data   lane 1 result, younger (owns port 1)
//   ld_valid/ld_reg/ld_data         load return; accepted when ld_ready
//   ld_ready                        queue has room (from registered count)
//   regwrite/wrreg/wrdata           registered write port 0
//   regwrite1/wrreg1/wrdata1        registered write port 1
//   ld_pending                      only with REGWB_SCOREBOARD_EN defined:
//                                   bit r set while a valid queued load
//                                   targets register r
// Age order within a cycle: queued loads (head first) < incoming load <
// lane 0 < lane 1.
module regwb_arb
  import regwb_pkg::*;
#(
  parameter int LDQ_DEPTH = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu0_valid,
  input  logic [REG_W-1:0]  alu0_reg,
  input  logic [DATA_W-1:0] alu0_data,
  input  logic              alu1_valid,
  input  logic [REG_W-1:0]  alu1_reg,
  input  logic [DATA_W-1:0] alu1_data,
  input  logic              ld_valid,
  input  logic [REG_W-1:0]  ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              regwrite,
  output logic [REG_W-1:0]  wrreg,
  output logic [DATA_W-1:0] wrdata,
  output logic              regwrite1,
  output logic [REG_W-1:0]  wrreg1,
  output logic [DATA_W-1:0] wrdata1
`ifdef REGWB_SCOREBOARD_EN
  ,
  output logic [NREG-1:0]   ld_pending
`endif
);

  localparam int CNT_W = $clog2(LDQ_DEPTH) + 1;

  function automatic logic alu_hit(input logic [REG_W-1:0] rd,
                                   input logic a0l, input logic [REG_W-1:0] a0r,
                                   input logic a1l, input logic [REG_W-1:0] a1r);
    return (a0l && (rd == a0r)) || (a1l && (rd == a1r));
  endfunction

  logic [CNT_W-1:0]         q_count;
  ldq_tag_t [LDQ_DEPTH-1:0] q_tags;
  ldq_tag_t                 head_tag, next_tag, push_tag;
  logic [DATA_W-1:0]        head_data, next_data;
  logic [LDQ_DEPTH-1:0]     kill;
  logic [1:0]               pop_cnt;
  logic                     push;

  logic             a0_live, a1_live, a0_wr, a1_wr;
  logic [1:0]       ports_free, ports_left;
  logic             h_exist, h_live, pop_h, h_wr;
  logic             n_exist, n_live, pop_n, n_wr;
  logic             ld_acc, ld_live, b_wr;
  logic             f_wr, s_wr;
  logic [REG_W-1:0] f_rd, s_rd;
  logic [DATA_W-1:0] f_data, s_data;

  logic              wr0_p0, wr1_p0;
  logic [REG_W-1:0]  rd0_p0, rd1_p0;
  logic [DATA_W-1:0] data0_p0, data1_p0;

  regwb_ldq #(.LDQ_DEPTH(LDQ_DEPTH), .DATA_W(DATA_W)) u_ldq (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_tag  (push_tag),
    .push_data (ld_data),
    .pop_cnt   (pop_cnt),
    .kill      (kill),
    .count     (q_count),
    .tags      (q_tags),
    .head_tag  (head_tag),
    .next_tag  (next_tag),
    .head_data (head_data),
    .next_data (next_data)
  );

  assign ld_ready = (q_count < CNT_W'(LDQ_DEPTH));

  // Stage p0: port allocation and WAW suppression (combinational).
  // a0_live still kills loads when lane 0 itself loses to lane 1.
  assign a0_live = reg_live(alu0_valid, alu0_reg);
  assign a1_live = reg_live(alu1_valid, alu1_reg);
  assign a0_wr   = a0_live && !(a1_live && (alu1_reg == alu0_reg));
  assign a1_wr   = a1_live;

  always_comb begin
    kill = '0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      kill[i] = q_tags[i].vld &&
                alu_hit(q_tags[i].rd, a0_live, alu0_reg, a1_live, alu1_reg);
    end
  end

  // A port is free only when its lane presents nothing at all.
  assign ports_free = {1'b0, !alu0_valid} + {1'b0, !alu1_valid};

  // Dead entries (killed earlier or this cycle) retire without a port;
  // head+1 can only retire behind the head.
  assign h_exist    = (q_count != '0);
  assign h_live     = h_exist && head_tag.vld &&
                      !alu_hit(head_tag.rd, a0_live, alu0_reg, a1_live, alu1_reg);
  assign h_wr       = h_live && (ports_free != 2'd0);
  assign pop_h      = h_exist && (!h_live || h_wr);
  assign ports_left = ports_free - {1'b0, h_wr};

  assign n_exist = pop_h && (q_count >= CNT_W'(2));
  assign n_live  = n_exist && next_tag.vld &&
                   !alu_hit(next_tag.rd, a0_live, alu0_reg, a1_live, alu1_reg);
  assign n_wr    = n_live && (ports_left != 2'd0);
  assign pop_n   = n_exist && (!n_live || n_wr);
  assign pop_cnt = {1'b0, pop_h} + {1'b0, pop_n};

  // Incoming load: direct write only into an empty queue; reg 0 is accepted
  // and dropped; anything else goes to the tail, pre-killed if an ALU lane
  // writes the same register this cycle.
  assign ld_acc   = ld_valid && ld_ready;
  assign ld_live  = (ld_reg != REG_ZERO) &&
                    !alu_hit(ld_reg, a0_live, alu0_reg, a1_live, alu1_reg);
  assign b_wr     = ld_acc && (q_count == '0) && ld_live && (ports_free != 2'd0);
  assign push     = ld_acc && (ld_reg != REG_ZERO) && !b_wr;
  assign push_tag = '{vld: ld_live, rd: ld_reg};

  // Order load writes oldest first; the head is dropped when head+1 writes
  // the same register in the same cycle.
  always_comb begin
    f_wr   = 1'b0;
    f_rd   = '0;
    f_data = '0;
    s_wr   = 1'b0;
    s_rd   = '0;
    s_data = '0;
    if (h_wr) begin
      f_wr   = !(n_wr && (next_tag.rd == head_tag.rd));
      f_rd   = head_tag.rd;
      f_data = head_data;
      if (n_wr) begin
        s_wr   = 1'b1;
        s_rd   = next_tag.rd;
        s_data = next_data;
      end
    end else if (n_wr) begin
      f_wr   = 1'b1;
      f_rd   = next_tag.rd;
      f_data = next_data;
    end else if (b_wr) begin
      f_wr   = 1'b1;
      f_rd   = ld_reg;
      f_data = ld_data;
    end
  end

  always_comb begin
    if (alu0_valid) begin
      wr0_p0 = a0_wr; rd0_p0 = alu0_reg; data0_p0 = alu0_data;
    end else begin
      wr0_p0 = f_wr;  rd0_p0 = f_rd;     data0_p0 = f_data;
    end
    if (alu1_valid) begin
      wr1_p0 = a1_wr; rd1_p0 = alu1_reg; data1_p0 = alu1_data;
    end else if (alu0_valid) begin
      wr1_p0 = f_wr;  rd1_p0 = f_rd;     data1_p0 = f_data;
    end else begin
      wr1_p0 = s_wr;  rd1_p0 = s_rd;     data1_p0 = s_data;
    end
  end

  // Stage p1: registered write ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite  <= 1'b0;
      wrreg     <= '0;
      wrdata    <= '0;
      regwrite1 <= 1'b0;
      wrreg1    <= '0;
      wrdata1   <= '0;
    end else begin
      regwrite  <= wr0_p0;
      wrreg     <= rd0_p0;
      wrdata    <= data0_p0;
      regwrite1 <= wr1_p0;
      wrreg1    <= rd1_p0;
      wrdata1   <= data1_p0;
    end
  end

`ifdef REGWB_SCOREBOARD_EN
  // Decoded straight from the queue tags, so it changes on the same edge.
  always_comb begin
    ld_pending = '0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (q_tags[i].vld) ld_pending[q_tags[i].rd] = 1'b1;
    end
    ld_pending[REG_ZERO] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_regwb_arb.sv
module tb_regwb_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu0_valid, alu1_valid, ld_valid;
  logic [4:0]  alu0_reg, alu1_reg, ld_reg;
  logic [31:0] alu0_data, alu1_data, ld_data;
  logic        ld_ready;
  logic        regwrite, regwrite1;
  logic [4:0]  wrreg, wrreg1;
  logic [31:0] wrdata, wrdata1;
`ifdef REGWB_SCOREBOARD_EN
  logic [31:0] ld_pending;
`endif

  int total = 0;
  int bad   = 0;

  regwb_arb #(.LDQ_DEPTH(4), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu0_valid (alu0_valid),
    .alu0_reg   (alu0_reg),
    .alu0_data  (alu0_data),
    .alu1_valid (alu1_valid),
    .alu1_reg   (alu1_reg),
    .alu1_data  (alu1_data),
    .ld_valid   (ld_valid),
    .ld_reg     (ld_reg),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .regwrite   (regwrite),
    .wrreg      (wrreg),
    .wrdata     (wrdata),
    .regwrite1  (regwrite1),
    .wrreg1     (wrreg1),
    .wrdata1    (wrdata1)
`ifdef REGWB_SCOREBOARD_EN
    ,
    .ld_pending (ld_pending)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        a0v; logic [4:0] a0r; logic [31:0] a0d;
    logic        a1v; logic [4:0] a1r; logic [31:0] a1d;
    logic        lv;  logic [4:0] lr;  logic [31:0] ld;
    logic        rdy;
    logic        w0;  logic [4:0] r0;  logic [31:0] d0;
    logic        w1;  logic [4:0] r1;  logic [31:0] d1;
    logic [31:0] pend;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic a0v, input int a0r, input logic [31:0] a0d,
                              input logic a1v, input int a1r, input logic [31:0] a1d,
                              input logic lv, input int lr, input logic [31:0] ld,
                              input logic rdy,
                              input logic w0, input int r0, input logic [31:0] d0,
                              input logic w1, input int r1, input logic [31:0] d1,
                              input logic [31:0] pend);
    vec_t v;
    v.a0v = a0v; v.a0r = 5'(a0r); v.a0d = a0d;
    v.a1v = a1v; v.a1r = 5'(a1r); v.a1d = a1d;
    v.lv  = lv;  v.lr  = 5'(lr);  v.ld  = ld;
    v.rdy = rdy;
    v.w0  = w0;  v.r0  = 5'(r0);  v.d0  = d0;
    v.w1  = w1;  v.r1  = 5'(r1);  v.d1  = d1;
    v.pend = pend;
    return v;
  endfunction

  function automatic logic [31:0] bm(input int n);
    return 32'd1 << n;
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%h required=%h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    alu0_valid = v.a0v; alu0_reg = v.a0r; alu0_data = v.a0d;
    alu1_valid = v.a1v; alu1_reg = v.a1r; alu1_data = v.a1d;
    ld_valid   = v.lv;  ld_reg   = v.lr;  ld_data   = v.ld;
  endtask

  task automatic check_ports(input vec_t v, input int row);
    if (v.w0) chk("port0", row, 64'({regwrite, wrreg, wrdata}), 64'({1'b1, v.r0, v.d0}));
    else      chk("port0_idle", row, 64'(regwrite), 64'd0);
    if (v.w1) chk("port1", row, 64'({regwrite1, wrreg1, wrdata1}), 64'({1'b1, v.r1, v.d1}));
    else      chk("port1_idle", row, 64'(regwrite1), 64'd0);
`ifdef REGWB_SCOREBOARD_EN
    chk("ld_pending", row, 64'(ld_pending), 64'(v.pend));
`endif
  endtask

  task automatic apply(input vec_t v, input int row);
    @(negedge clk);
    drive(v);
    #1;
    chk("ld_ready", row, 64'(ld_ready), 64'(v.rdy));
    @(posedge clk);
    #1;
    check_ports(v, row);
  endtask

  task automatic check_cleared(input string nm);
    chk({nm, "_port0"}, -1, 64'({regwrite, wrreg, wrdata}), 64'd0);
    chk({nm, "_port1"}, -1, 64'({regwrite1, wrreg1, wrdata1}), 64'd0);
    chk({nm, "_ld_ready"}, -1, 64'(ld_ready), 64'd1);
`ifdef REGWB_SCOREBOARD_EN
    chk({nm, "_ld_pending"}, -1, 64'(ld_pending), 64'd0);
`endif
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0, 0,0,0, 0,0,0, 1, 0,0,0, 0,0,0, 0);

    // basic dual ALU write, then lane1-over-lane0 WAW
    tv.push_back(mk(1,8,'h11, 1,9,'h22, 0,0,0, 1, 1,8,'h11, 1,9,'h22, 0));
    tv.push_back(idle);
    tv.push_back(mk(1,5,'hA, 1,5,'hB, 0,0,0, 1, 0,0,0, 1,5,'hB, 0));
    // fill the queue while both lanes are busy, fifth load refused
    tv.push_back(mk(1,1,'h100, 1,2,'h200, 1,10,'hA0, 1, 1,1,'h100, 1,2,'h200, bm(10)));
    tv.push_back(mk(1,1,'h101, 1,2,'h201, 1,11,'hB0, 1, 1,1,'h101, 1,2,'h201, bm(10)|bm(11)));
    tv.push_back(mk(1,1,'h102, 1,2,'h202, 1,12,'hC0, 1, 1,1,'h102, 1,2,'h202, bm(10)|bm(11)|bm(12)));
    tv.push_back(mk(1,1,'h103, 1,2,'h203, 1,13,'hD0, 1, 1,1,'h103, 1,2,'h203, bm(10)|bm(11)|bm(12)|bm(13)));
    tv.push_back(mk(1,1,'h104, 1,2,'h204, 1,14,'hE0, 0, 1,1,'h104, 1,2,'h204, bm(10)|bm(11)|bm(12)|bm(13)));
    // lanes idle: drain two per cycle in order, held load enters behind
    tv.push_back(mk(0,0,0, 0,0,0, 1,14,'hE0, 0, 1,10,'hA0, 1,11,'hB0, bm(12)|bm(13)));
    tv.push_back(mk(0,0,0, 0,0,0, 1,14,'hE0, 1, 1,12,'hC0, 1,13,'hD0, bm(14)));
    tv.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1, 1,14,'hE0, 0,0,0, 0));
    tv.push_back(idle);
    // queued load killed by a younger ALU write
    tv.push_back(mk(1,1,'h1, 1,2,'h2, 1,7,'h77, 1, 1,1,'h1, 1,2,'h2, bm(7)));
    tv.push_back(mk(0,0,0, 1,7,'h5, 0,0,0, 1, 0,0,0, 1,7,'h5, 0));
    tv.push_back(idle);
    // register zero
    tv.push_back(mk(0,0,0, 0,0,0, 1,0,'h99, 1, 0,0,0, 0,0,0, 0));
    tv.push_back(mk(1,0,'h33, 0,0,0, 0,0,0, 1, 0,0,0, 0,0,0, 0));
    tv.push_back(idle);
    // two queued loads to the same register: only the younger is written
    tv.push_back(mk(1,1,'h3, 1,2,'h4, 1,20,'h1, 1, 1,1,'h3, 1,2,'h4, bm(20)));
    tv.push_back(mk(1,1,'h5, 1,2,'h6, 1,20,'h2, 1, 1,1,'h5, 1,2,'h6, bm(20)));
    tv.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1, 0,0,0, 1,20,'h2, 0));
    // direct bypass into port0, then into port1 beside lane 0
    tv.push_back(mk(0,0,0, 0,0,0, 1,3,'h33, 1, 1,3,'h33, 0,0,0, 0));
    tv.push_back(mk(1,4,'h44, 0,0,0, 1,6,'h66, 1, 1,4,'h44, 1,6,'h66, 0));
    // incoming load overwritten by lane 0 in the same cycle
    tv.push_back(mk(1,9,'h9, 0,0,0, 1,9,'h90, 1, 1,9,'h9, 0,0,0, 0));
    tv.push_back(idle);
    // queue head goes to port1 when only lane 1 is idle
    tv.push_back(mk(1,1,'h7, 1,2,'h8, 1,11,'h11, 1, 1,1,'h7, 1,2,'h8, bm(11)));
    tv.push_back(mk(1,3,'h3, 0,0,0, 0,0,0, 1, 1,3,'h3, 1,11,'h11, 0));

    reset = 1'b1;
    drive(idle);
    #2;
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++) apply(tv[i], i);

    // reset in the middle of a cycle with three loads queued
    apply(mk(1,1,'hAAA1, 1,2,'hAAA2, 1,10,'h10, 1, 1,1,'hAAA1, 1,2,'hAAA2, bm(10)), 100);
    apply(mk(1,1,'hBBB1, 1,2,'hBBB2, 1,11,'h11, 1, 1,1,'hBBB1, 1,2,'hBBB2, bm(10)|bm(11)), 101);
    apply(mk(1,1,'hCCC1, 1,2,'hCCC2, 1,12,'h12, 1, 1,1,'hCCC1, 1,2,'hCCC2, bm(10)|bm(11)|bm(12)), 102);
    #2;
    reset = 1'b1;
    #1;
    check_cleared("reset_mid");
    @(negedge clk);
    drive(idle);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_ports(idle, 103);
    apply(idle, 104);
    apply(idle, 105);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
